// File: rtl/frame_sequencer_pkg.sv
// Shared constants and state encoding for the frame sequencer and its raster counter.
package frame_sequencer_pkg;

    // Frame geometry and pixel format.
    localparam int FRAME_WIDTH  = 640;
    localparam int FRAME_HEIGHT = 480;
    localparam int PIXEL_SIZE   = 24;

    // Advance cycles between a pixel entering the Sobel/flood/CC chain and its result.
    localparam int LATENCY      = 2 * FRAME_WIDTH + 6;

    // Width of the pipe_x / pipe_y coordinate buses.
    localparam int COORD_WIDTH  = 16;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_CLEAR = 3'd1,
        FS_RUN   = 3'd2,
        FS_FLUSH = 3'd3,
        FS_DRAIN = 3'd4,
        FS_DONE  = 3'd5
    } fs_state_t;

endpackage

// File: rtl/frame_sequencer_raster_counter.sv
// Raster-order x/y generator: x wraps at the row end and bumps y; y saturates at all-ones
// so that flush advances past the last row never wrap back into the frame.
module raster_counter
    import frame_sequencer_pkg::*;
#(
    parameter int ROW_LEN = frame_sequencer_pkg::FRAME_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   en,
    output logic [COORD_WIDTH-1:0] x,
    output logic [COORD_WIDTH-1:0] y
);

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(ROW_LEN - 1);
    localparam logic [COORD_WIDTH-1:0] Y_MAX  = {COORD_WIDTH{1'b1}};

    logic [COORD_WIDTH-1:0] x_r;
    logic [COORD_WIDTH-1:0] y_r;
    logic [COORD_WIDTH-1:0] x_nxt_s;
    logic [COORD_WIDTH-1:0] y_nxt_s;

    // Next-coordinate logic: clear wins, otherwise step on enable with wrap and saturation.
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        if (clear) begin
            x_nxt_s = {COORD_WIDTH{1'b0}};
            y_nxt_s = {COORD_WIDTH{1'b0}};
        end else if (en) begin
            if (x_r == X_LAST) begin
                x_nxt_s = {COORD_WIDTH{1'b0}};
                if (y_r != Y_MAX) begin
                    y_nxt_s = y_r + {{(COORD_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    y_nxt_s = y_r;
                end
            end else begin
                x_nxt_s = x_r + {{(COORD_WIDTH-1){1'b0}}, 1'b1};
                y_nxt_s = y_r;
            end
        end else begin
            x_nxt_s = x_r;
            y_nxt_s = y_r;
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r <= {COORD_WIDTH{1'b0}};
            y_r <= {COORD_WIDTH{1'b0}};
        end else begin
            x_r <= x_nxt_s;
            y_r <= y_nxt_s;
        end
    end

    assign x = x_r;
    assign y = y_r;

endmodule

// File: rtl/frame_sequencer.sv
// Sequences one pixel pipeline through a frame: clear, feed host pixels in raster order,
// flush the pipeline latency with zero pixels, and re-time results into a valid/ready stream.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_WIDTH  = frame_sequencer_pkg::FRAME_WIDTH,
    parameter int FRAME_HEIGHT = frame_sequencer_pkg::FRAME_HEIGHT,
    parameter int LATENCY      = frame_sequencer_pkg::LATENCY,
    parameter int CNT_WIDTH    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    output logic        pipe_reset_n,
    output logic        pipe_en,
    output logic [15:0] pipe_x,
    output logic [15:0] pipe_y,
    output logic [23:0] pipe_data,
    input  logic [23:0] pipe_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [CNT_WIDTH-1:0] LAST_PIX = CNT_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_ADV = CNT_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT + LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] LAT_CNT  = CNT_WIDTH'(LATENCY);

    fs_state_t              state_r;
    fs_state_t              state_nxt_s;
    logic [CNT_WIDTH-1:0]   adv_cnt_r;
    logic                   out_valid_r;
    logic [PIXEL_SIZE-1:0]  out_data_r;
    logic                   out_ok_s;
    logic                   adv_s;
    logic                   in_run_s;
    logic                   in_flush_s;
    logic                   in_clear_s;
    logic                   result_s;

    assign in_run_s   = (state_r == FS_RUN);
    assign in_flush_s = (state_r == FS_FLUSH);
    assign in_clear_s = (state_r == FS_CLEAR);

    // The output register is a one-entry slot: the pipeline may advance only if it can take a result.
    assign out_ok_s = !out_valid_r || out_ready;
    assign adv_s    = out_ok_s && ((in_run_s && in_valid) || in_flush_s);
    assign result_s = adv_s && (adv_cnt_r >= LAT_CNT);

    assign in_ready     = in_run_s && out_ok_s;
    assign pipe_en      = adv_s;
    assign pipe_data    = in_run_s ? in_data : 24'd0;
    assign pipe_reset_n = !in_clear_s;
    assign busy         = (state_r != FS_IDLE);
    assign frame_done   = (state_r == FS_DONE);
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;

    raster_counter #(
        .ROW_LEN (FRAME_WIDTH)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .clear (in_clear_s),
        .en    (adv_s),
        .x     (pipe_x),
        .y     (pipe_y)
    );

    // Next-state logic for the frame control FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FS_IDLE: begin
                if (start) begin
                    state_nxt_s = FS_CLEAR;
                end else begin
                    state_nxt_s = FS_IDLE;
                end
            end
            FS_CLEAR: begin
                state_nxt_s = FS_RUN;
            end
            FS_RUN: begin
                if (adv_s && (adv_cnt_r == LAST_PIX)) begin
                    state_nxt_s = (LATENCY == 0) ? FS_DRAIN : FS_FLUSH;
                end else begin
                    state_nxt_s = FS_RUN;
                end
            end
            FS_FLUSH: begin
                if (adv_s && (adv_cnt_r == LAST_ADV)) begin
                    state_nxt_s = FS_DRAIN;
                end else begin
                    state_nxt_s = FS_FLUSH;
                end
            end
            FS_DRAIN: begin
                if (out_ok_s) begin
                    state_nxt_s = FS_DONE;
                end else begin
                    state_nxt_s = FS_DRAIN;
                end
            end
            FS_DONE: begin
                state_nxt_s = FS_IDLE;
            end
            default: begin
                state_nxt_s = FS_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FS_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Advance counter: index of the current pipeline advance within the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adv_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (in_clear_s) begin
            adv_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (adv_s) begin
            adv_cnt_r <= adv_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            adv_cnt_r <= adv_cnt_r;
        end
    end

    // Output slot: load once the pipeline is primed, otherwise empty it when the sink takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {PIXEL_SIZE{1'b0}};
        end else if (result_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= pipe_out;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

endmodule
